// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for a combinational ALU.
// Accepts one decoded operation per request handshake and drives the ALU for
// one cycle. It keeps the architectural C/Z/S flags and returns the result to
// the register file over a valid/ready write-back port. A MUL can write back
// a second beat that carries the high byte.
module alu_exec_ctrl #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter bit          MUL_HI_WB  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_opcode,
  input  logic [7:0]            req_op1,
  input  logic [7:0]            req_op2,
  input  logic [REG_ADDR_W-1:0] req_dest,
  output logic                  alu_enable,
  output logic [7:0]            alu_operation,
  output logic [7:0]            alu_op1,
  output logic [7:0]            alu_op2,
  output logic                  alu_cpu_carry,
  input  logic [7:0]            alu_result_l,
  input  logic [7:0]            alu_result_h,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  input  logic                  alu_sign,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [7:0]            wb_data,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  flag_s,
  output logic                  illegal_op,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB_L, S_WB_H} state_t;

  localparam logic [REG_ADDR_W-1:0] ADDR_ONE = 1;

  state_t                state;
  logic [7:0]            opcode_q;
  logic [7:0]            op1_q;
  logic [7:0]            op2_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [7:0]            res_h_q;
  logic                  ready_q;

  // Two-operand ops are 0x88-0x9F. Single-operand ops are 0x01-0x0A and SETB/CLRB (0x60-0x6F).
  function automatic logic is_legal(input logic [7:0] op);
    return (op[7] && (op[6:1] >= 6'd4) && (op[6:1] <= 6'd15)) ||
           ((op >= 8'h01) && (op <= 8'h0A)) ||
           (op[7:4] == 4'h6);
  endfunction

  function automatic logic is_mul(input logic [7:0] op);
    return op[7:2] == 6'b100100;
  endfunction

  function automatic logic is_flag_only(input logic [7:0] op);
    return (op == 8'h04) || (op == 8'h05);
  endfunction

  function automatic logic is_carry_wr(input logic [7:0] op);
    return (op[7:2] == 6'b100010) || (op == 8'h02) || (op == 8'h04) ||
           (op == 8'h05) || (op == 8'h08) || (op == 8'h09);
  endfunction

  // The operand bus always shows the latched request, and carry-in is always the live C flag.
  assign alu_operation = opcode_q;
  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign alu_cpu_carry = flag_c;
  // Ready is held low while reset is active, even though its register resets to 1.
  assign req_ready     = ready_q & rst;

  // Sequencer FSM. Every handshake/strobe output is registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      opcode_q   <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      dest_q     <= '0;
      res_h_q    <= '0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
      flag_s     <= 1'b0;
      illegal_op <= 1'b0;
      alu_enable <= 1'b0;
      busy       <= 1'b0;
      ready_q    <= 1'b1;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      illegal_op <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            opcode_q <= req_opcode;
            op1_q    <= req_op1;
            op2_q    <= req_op2;
            dest_q   <= req_dest;
            if (is_legal(req_opcode)) begin
              state      <= S_EXEC;
              alu_enable <= 1'b1;
              busy       <= 1'b1;
              ready_q    <= 1'b0;
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          // wb_data doubles as the captured low result, so WB_L needs no extra copy.
          alu_enable <= 1'b0;
          res_h_q    <= alu_result_h;
          flag_z     <= alu_zero;
          flag_s     <= alu_sign;
          if (is_carry_wr(opcode_q)) flag_c <= alu_carry;
          if (is_flag_only(opcode_q)) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            state    <= S_WB_L;
            wb_valid <= 1'b1;
            wb_addr  <= dest_q;
            wb_data  <= alu_result_l;
          end
        end
        S_WB_L: begin
          if (wb_ready) begin
            if (MUL_HI_WB && is_mul(opcode_q)) begin
              state   <= S_WB_H;
              wb_addr <= dest_q + ADDR_ONE;
              wb_data <= res_h_q;
            end else begin
              state    <= S_IDLE;
              wb_valid <= 1'b0;
              wb_addr  <= '0;
              wb_data  <= '0;
              busy     <= 1'b0;
              ready_q  <= 1'b1;
            end
          end
        end
        S_WB_H: begin
          if (wb_ready) begin
            state    <= S_IDLE;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            busy     <= 1'b0;
            ready_q  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Execute-stage sequencer on the initiator side of the combinational ALU interface. It accepts one decoded operation per handshake, drives the ALU enable, operation, operand and carry-in lines for one cycle, and captures the result and flags. It then holds the architectural C/Z/S flag register and issues the result to the register file over a valid/ready write-back port. It sits between instruction decode and the register file.

Parameters:
REG_ADDR_W, 3, width of destination register index; MUL high-byte destination = (dest + 1) mod 2^REG_ADDR_W
MUL_HI_WB, 1, 1 = MUL writes back high byte as second beat; 0 = low byte only

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  operation request valid
req_ready  output  1  controller can accept request (IDLE only)
req_opcode  input  8  ALU operation code
req_op1  input  8  first operand
req_op2  input  8  second operand (ignored for single-operand ops)
req_dest  input  REG_ADDR_W  destination register index
alu_enable  output  1  ALU enable, high only in EXEC
alu_operation  output  8  latched opcode to ALU
alu_op1  output  8  latched op1 to ALU
alu_op2  output  8  latched op2 to ALU
alu_cpu_carry  output  1  current flag_c to ALU
alu_result_l  input  8  ALU low result
alu_result_h  input  8  ALU high result (MUL)
alu_carry  input  1  ALU carry out
alu_zero  input  1  ALU zero out
alu_sign  input  1  ALU sign out
wb_valid  output  1  write-back beat valid
wb_ready  input  1  register file accepts beat
wb_addr  output  REG_ADDR_W  write-back register index
wb_data  output  8  write-back data
flag_c  output  1  architectural carry
flag_z  output  1  architectural zero
flag_s  output  1  architectural sign
illegal_op  output  1  one-cycle pulse: rejected opcode
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except req_ready=1 once rst deasserts; latched opcode/operands/results cleared; pending write-back dropped.
- Legal opcodes:
  - two-operand: bit7=1, bits[6:1] in 000100..001111 (0x88-0x9F)
  - single-operand: 0x01-0x0A, SETB 0x60-0x67, CLRB 0x68-0x6F
  - all others illegal
- Classes:
  - MUL = 0x90-0x93
  - flag-only = SETC 0x04, CLRC 0x05 (no write-back)
  - carry-writers = ADD 0x88-0x8B, INC 0x02, SETC, CLRC, RLC 0x08, RRC 0x09
- FSM states IDLE, EXEC, WB_L, WB_H:
  - IDLE: req_ready=1. On req_valid, latch opcode/op1/op2/dest.
    - legal opcode -> EXEC
    - illegal opcode -> stay IDLE, illegal_op=1 next cycle, flags unchanged
  - EXEC (exactly 1 cycle): alu_enable=1, alu_cpu_carry=flag_c. At the closing edge:
    - capture alu_result_l/h into regs
    - flag_z <= alu_zero, flag_s <= alu_sign
    - flag_c <= alu_carry only for carry-writers, else held
    - next state: flag-only -> IDLE; else -> WB_L
  - WB_L: wb_valid=1, wb_addr=dest, wb_data=captured result_l; held stable until wb_ready.
    - on handshake: MUL with MUL_HI_WB=1 -> WB_H; else -> IDLE
  - WB_H: wb_valid=1, wb_addr=dest+1 (wraps 7->0 at default width), wb_data=captured result_h; on handshake -> IDLE.
- Latency: accept edge -> EXEC 1 cycle -> wb_valid asserted the cycle after EXEC. Minimum 3 cycles per op; 4 for MUL two-beat.
- No new request is accepted until return to IDLE. Back-to-back ops: the next request is accepted the cycle after the final handshake, and its EXEC sees the updated flag_c (ADC chaining).
- alu_operation/op1/op2 reflect latched values at all times. alu_enable=0 outside EXEC.
- wb_ready asserted outside WB_L/WB_H is ignored.
- Mid-operation reset: immediate return to IDLE, flags cleared, no partial write-back.

Test Plan:
- ADD with carry: flag_c=0, opcode 0x88, op1=0xF0, op2=0x20, dest=2 -> EXEC one cycle later; wb (2, 0x10); flag_c=1, flag_z=0. Then 0x88, 0x01+0x01 -> wb 0x03 (carry-in used), flag_c=0.
- MUL two-beat: 0x90, 0x10*0x20, dest=7 -> beats (7, 0x00) then (0, 0x02); flag_z=0; with MUL_HI_WB=0 -> single beat (7, 0x00).
- Flag preservation: set flag_c=1 via 0x04 (no wb_valid ever); then SUB 0x8C, 0x05-0x05 -> wb 0x00, flag_z=1, flag_s=0, flag_c stays 1.
- Back-pressure: wb_ready low 3 cycles during WB_L -> wb_valid/addr/data stable, req_ready=0, busy=1; a req_valid pulse in that window is not accepted.
- Illegal: opcode 0x80 -> illegal_op high exactly one cycle, alu_enable never high, no wb_valid, flags unchanged, req_ready stays 1.
- Reset mid-op: assert rst=0 during WB_H of a MUL -> wb_valid, flags, busy drop to 0 asynchronously; after release, the first op completes normally.
